// File: rtl/envelope_gen.sv
// envelope_gen -- linear ADSR envelope generator.
//
// Produces a non-negative signed gain word (0..2^(BITSIZE-1)-1) for the
// voice attenuator. The envelope advances one step on every cycle where
// sample_tick is high; on all other cycles every register holds.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   sample_tick    one-cycle audio-rate update strobe
//   gate           note on (1) / off (0), level-sensitive
//   attack_step    unsigned increment per tick in ATTACK
//   decay_step     unsigned decrement per tick in DECAY
//   sustain_level  unsigned sustain target (tracked live in SUSTAIN)
//   release_step   unsigned decrement per tick in RELEASE
//   out            registered gain word, MSB always 0
//   state          registered phase: IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   active         registered, high whenever state is not IDLE

module envelope_gen #(
  parameter int BITSIZE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_tick,
  input  logic                      gate,
  input  logic [BITSIZE-2:0]        attack_step,
  input  logic [BITSIZE-2:0]        decay_step,
  input  logic [BITSIZE-2:0]        sustain_level,
  input  logic [BITSIZE-2:0]        release_step,
  output logic signed [BITSIZE-1:0] out,
  output logic [2:0]                state,
  output logic                      active
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } env_state_e;

  // Level is one bit wider than out: level + step (both below 2^(BITSIZE-1))
  // always fits, so the attack sum never wraps before clamping.
  localparam int LW = BITSIZE + 1;
  localparam logic [LW-1:0] MAX = {2'b00, {(BITSIZE-1){1'b1}}};

  env_state_e      state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic            active_q;

  logic [LW-1:0]   att_ext, dec_ext, sus_ext, rel_ext;
  logic [LW-1:0]   attack_sum, attack_val;
  logic [LW-1:0]   decay_floor, decay_val;
  logic [LW-1:0]   release_val;

  assign att_ext = {2'b00, attack_step};
  assign dec_ext = {2'b00, decay_step};
  assign sus_ext = {2'b00, sustain_level};
  assign rel_ext = {2'b00, release_step};

  // ATTACK: min(level + step, MAX)
  assign attack_sum = level_q + att_ext;
  assign attack_val = (attack_sum >= MAX) ? MAX : attack_sum;

  // DECAY: max(level - step, sustain). Comparing against sustain + step
  // avoids forming a possibly underflowing difference first.
  assign decay_floor = sus_ext + dec_ext;
  assign decay_val   = (level_q >= decay_floor) ? (level_q - dec_ext) : sus_ext;

  // RELEASE: max(level - step, 0)
  assign release_val = (level_q > rel_ext) ? (level_q - rel_ext) : '0;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to remember the old value.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (sample_tick) begin
      // Gate changes take priority over the per-phase level rules.
      if (gate && (state_q == S_IDLE || state_q == S_RELEASE)) begin
        // Retrigger continues from the current level rather than from 0.
        state_d = S_ATTACK;
        level_d = attack_val;
      end else if (!gate && (state_q == S_ATTACK || state_q == S_DECAY ||
                             state_q == S_SUSTAIN)) begin
        state_d = S_RELEASE;
        level_d = release_val;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            level_d = '0;
          end
          S_ATTACK: begin
            level_d = attack_val;
            if (attack_val == MAX) state_d = S_DECAY;
          end
          S_DECAY: begin
            level_d = decay_val;
            if (decay_val == sus_ext) state_d = S_SUSTAIN;
          end
          S_SUSTAIN: begin
            // Follows sustain_level with no slew.
            level_d = sus_ext;
          end
          S_RELEASE: begin
            level_d = release_val;
            if (release_val == '0) state_d = S_IDLE;
          end
          default: begin
            state_d = S_IDLE;
            level_d = '0;
          end
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      active_q <= (state_d != S_IDLE);
    end
  end

  // Level never exceeds MAX, so the dropped top bit is always 0.
  assign out    = signed'(level_q[BITSIZE-1:0]);
  assign state  = state_q;
  assign active = active_q;

endmodule

// File: tb/tb_envelope_gen.sv
// Testbench for envelope_gen: integer-arithmetic reference model checked
// every cycle, plus hand-computed literal expectations at key points.

module tb_envelope_gen;

  localparam int BITSIZE = 16;
  localparam int MAXV    = 32767;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      sample_tick = 1'b0;
  logic                      gate = 1'b0;
  logic [BITSIZE-2:0]        attack_step = '0;
  logic [BITSIZE-2:0]        decay_step = '0;
  logic [BITSIZE-2:0]        sustain_level = '0;
  logic [BITSIZE-2:0]        release_step = '0;
  logic signed [BITSIZE-1:0] out;
  logic [2:0]                state;
  logic                      active;

  int n_checks = 0;
  int n_fail   = 0;

  envelope_gen #(.BITSIZE(BITSIZE)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .out           (out),
    .state         (state),
    .active        (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase numbers and level as plain integers.
  int m_level = 0;
  int m_phase = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_level = 0;
      m_phase = 0;
    end else if (sample_tick) begin
      int a, d, s, r;
      a = int'(attack_step);
      d = int'(decay_step);
      s = int'(sustain_level);
      r = int'(release_step);
      if (gate && (m_phase == 0 || m_phase == 4)) begin
        m_phase = 1;
        m_level = (m_level + a > MAXV) ? MAXV : m_level + a;
      end else if (!gate && m_phase >= 1 && m_phase <= 3) begin
        m_phase = 4;
        m_level = (m_level - r < 0) ? 0 : m_level - r;
      end else if (m_phase == 0) begin
        m_level = 0;
      end else if (m_phase == 1) begin
        m_level = (m_level + a > MAXV) ? MAXV : m_level + a;
        if (m_level == MAXV) m_phase = 2;
      end else if (m_phase == 2) begin
        m_level = (m_level - d < s) ? s : m_level - d;
        if (m_level == s) m_phase = 3;
      end else if (m_phase == 3) begin
        m_level = s;
      end else begin
        m_level = (m_level - r < 0) ? 0 : m_level - r;
        if (m_level == 0) m_phase = 0;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("model_out",    int'(out),    m_level);
    check("model_state",  int'(state),  m_phase);
    check("model_active", int'(active), (m_phase != 0) ? 1 : 0);
  end

  // One isolated tick; outputs reflect it when the task returns.
  task automatic tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // n ticks on consecutive clocks.
  task automatic burst(input int n);
    @(negedge clk);
    sample_tick = 1'b1;
    repeat (n) @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic expect_lit(input string name, input int o, input int st, input int act);
    check({name, "_out"},    int'(out),    o);
    check({name, "_state"},  int'(state),  st);
    check({name, "_active"}, int'(active), act);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_lit("reset", 0, 0, 0);

    // Idle with ticks running and gate low.
    repeat (3) tick();
    expect_lit("idle", 0, 0, 0);

    // Attack saturation.
    attack_step = 15'd8192;
    gate = 1'b1;
    tick(); expect_lit("att1", 8192, 1, 1);
    tick(); expect_lit("att2", 16384, 1, 1);
    tick(); expect_lit("att3", 24576, 1, 1);
    tick(); expect_lit("att4", 32767, 2, 1);

    // Decay to sustain, then live sustain change.
    decay_step = 15'd5000;
    sustain_level = 15'd20000;
    tick(); expect_lit("dec1", 27767, 2, 1);
    tick(); expect_lit("dec2", 22767, 2, 1);
    tick(); expect_lit("dec3", 20000, 3, 1);
    sustain_level = 15'd10000;
    tick(); expect_lit("sus_move", 10000, 3, 1);

    // Release to idle.
    release_step = 15'd4000;
    gate = 1'b0;
    tick(); expect_lit("rel1", 6000, 4, 1);
    tick(); expect_lit("rel2", 2000, 4, 1);
    tick(); expect_lit("rel3", 0, 0, 0);

    // Back up to sustain 10000 (consecutive ticks), then release to 6000.
    gate = 1'b1;
    decay_step = 15'd30000;
    burst(5);
    expect_lit("resus", 10000, 3, 1);
    gate = 1'b0;
    tick(); expect_lit("rel_6000", 6000, 4, 1);

    // Retrigger from release keeps the level.
    attack_step = 15'd1000;
    gate = 1'b1;
    tick(); expect_lit("retrig", 7000, 1, 1);

    // Zero attack step stalls for 100 consecutive ticks.
    attack_step = 15'd0;
    burst(100);
    expect_lit("stall", 7000, 1, 1);

    // Gate toggling without ticks changes nothing.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gate = ~gate;
      attack_step = 15'(i * 3000);
    end
    gate = 1'b1;
    @(negedge clk);
    expect_lit("no_tick", 7000, 1, 1);

    // Gate drop on the tick that would saturate.
    attack_step = 15'd23000;
    tick(); expect_lit("to_30000", 30000, 1, 1);
    attack_step = 15'd8192;
    release_step = 15'd1000;
    gate = 1'b0;
    tick(); expect_lit("drop_sat", 29000, 4, 1);

    // Reach DECAY at 20000, then reset asynchronously mid-cycle.
    release_step = 15'd30000;
    tick(); expect_lit("rel_idle", 0, 0, 0);
    attack_step = 15'd16384;
    gate = 1'b1;
    tick(); expect_lit("att_a", 16384, 1, 1);
    tick(); expect_lit("att_b", 32767, 2, 1);
    sustain_level = 15'd0;
    decay_step = 15'd12767;
    tick(); expect_lit("dec_20000", 20000, 2, 1);
    #2;
    rst = 1'b1;
    #1;
    expect_lit("async_rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
